// File: rtl/gate_sweep_checker_pkg.sv
// Shared types, gate bit positions and the golden truth table for the gate sweep checker.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } gate_chk_state_t;

  // Bit positions inside the seven-wide gate output bus
  localparam int IDX_AND  = 0;
  localparam int IDX_OR   = 1;
  localparam int IDX_NOT  = 2;
  localparam int IDX_NAND = 3;
  localparam int IDX_NOR  = 4;
  localparam int IDX_XOR  = 5;
  localparam int IDX_XNOR = 6;

  localparam int GATE_W  = 7;
  localparam int NUM_VEC = 4;

  function automatic logic [GATE_W-1:0] gate_expect(input logic a, input logic b);
    logic [GATE_W-1:0] g;
    g           = '0;
    g[IDX_AND]  = a & b;
    g[IDX_OR]   = a | b;
    g[IDX_NOT]  = ~a;
    g[IDX_NAND] = ~(a & b);
    g[IDX_NOR]  = ~(a | b);
    g[IDX_XOR]  = a ^ b;
    g[IDX_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Bundle between the sweep checker and the gate block / status consumer.
// Latency: n/a (wires only).
// Backpressure: none; start is a level sampled by the checker only when idle.
interface gate_sweep_checker_if #(
  parameter int ERR_W = 3
);
  import gate_chk_pkg::*;

  logic              start;
  logic              a;
  logic              b;
  logic [GATE_W-1:0] gate_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [GATE_W-1:0] fail_mask;
  logic              first_fail_valid;
  logic [1:0]        first_fail_vec;
  logic [GATE_W-1:0] first_fail_obs;

  // Checker side
  modport master (
    input  start, gate_out,
    output a, b, busy, done, pass, err_count, fail_mask,
           first_fail_valid, first_fail_vec, first_fail_obs
  );

  // Environment side: gate block plus whoever launches runs
  modport slave (
    output start, gate_out,
    input  a, b, busy, done, pass, err_count, fail_mask,
           first_fail_valid, first_fail_vec, first_fail_obs
  );
endinterface

// File: rtl/gate_expect_model.sv
// Combinational golden model of the seven basic gates for one {a,b} vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
module gate_expect_model
  import gate_chk_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] golden
);

  assign golden = gate_expect(a, b);

endmodule

// File: rtl/gate_sweep_checker.sv
// BIST sweep: drives all four {a,b} vectors NUM_PASSES times, checks the seven gate outputs, reports a verdict.
// Latency: done pulses 1 + 4*NUM_PASSES*(SETTLE_CYCLES+1) cycles after start is accepted.
// Backpressure: none; start is ignored outside IDLE. GATE_CHK_FIRST_FAIL_EN enables first-failure capture.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int NUM_PASSES    = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_sweep_checker_if.master  bus
);

  localparam int ERR_W = $clog2(4 * NUM_PASSES + 1);
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  gate_chk_state_t   state_q, state_d;
  logic [1:0]        vec_q;
  logic [PW-1:0]     pass_cnt_q;
  logic [SW-1:0]     settle_q;
  logic [ERR_W-1:0]  err_q;
  logic [GATE_W-1:0] mask_q;
  logic              pass_q;

  logic              accept;
  logic              settle_last;
  logic              last_vec;
  logic              last_pass;
  logic              mismatch;
  logic [GATE_W-1:0] golden;
  logic [GATE_W-1:0] diff;

  gate_expect_model u_expect (
    .a      (vec_q[1]),
    .b      (vec_q[0]),
    .golden (golden)
  );

  assign diff        = bus.gate_out ^ golden;
  assign mismatch    = |diff;
  assign settle_last = (settle_q == SW'(SETTLE_CYCLES - 1));
  assign last_vec    = (vec_q == 2'(NUM_VEC - 1));
  assign last_pass   = (pass_cnt_q == PW'(NUM_PASSES - 1));

  // State register; reset dominates a simultaneous start
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        bus.busy = 1'b1;
        if (settle_last) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        bus.busy = 1'b1;
        state_d  = (last_vec && last_pass) ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Vector sequencing, settle timing and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= '0;
      pass_cnt_q <= '0;
      settle_q   <= '0;
      err_q      <= '0;
      mask_q     <= '0;
      pass_q     <= 1'b0;
    end else if (accept) begin
      vec_q      <= '0;
      pass_cnt_q <= '0;
      settle_q   <= '0;
      err_q      <= '0;
      mask_q     <= '0;
      pass_q     <= 1'b0;
    end else if (state_q == ST_DRIVE) begin
      settle_q <= settle_last ? '0 : settle_q + SW'(1);
    end else if (state_q == ST_CHECK) begin
      // One count per failing vector; saturation is a guard only, the width already fits 4*NUM_PASSES
      if (mismatch && (err_q != '1)) err_q <= err_q + ERR_W'(1);
      mask_q <= mask_q | diff;
      if (!last_vec) begin
        vec_q <= vec_q + 2'd1;
      end else if (!last_pass) begin
        vec_q      <= '0;
        pass_cnt_q <= pass_cnt_q + PW'(1);
      end else begin
        pass_q <= (err_q == '0) && !mismatch;
      end
    end
  end

  assign bus.a         = vec_q[1];
  assign bus.b         = vec_q[0];
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;
  assign bus.pass      = pass_q;

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic              ff_valid_q;
  logic [1:0]        ff_vec_q;
  logic [GATE_W-1:0] ff_obs_q;

  // Latch the first failing vector of a run and the raw outputs seen for it
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      ff_obs_q   <= '0;
    end else if ((state_q == ST_CHECK) && mismatch && !ff_valid_q) begin
      ff_valid_q <= 1'b1;
      ff_vec_q   <= vec_q;
      ff_obs_q   <= bus.gate_out;
    end
  end

  assign bus.first_fail_valid = ff_valid_q;
  assign bus.first_fail_vec   = ff_vec_q;
  assign bus.first_fail_obs   = ff_obs_q;
`else
  assign bus.first_fail_valid = 1'b0;
  assign bus.first_fail_vec   = '0;
  assign bus.first_fail_obs   = '0;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a default instance and a 2-pass / 3-settle instance, each around a faultable gate block.
// Latency: checks done timing against hand-computed cycle counts.
// Backpressure: exercises ignored start while busy/done, reset mid-run, and reset+start collisions.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   fault1 = 0;
  int   fault2 = 0;
  int   dsel = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gate_sweep_checker_if #(.ERR_W(3)) if1 ();
  gate_sweep_checker_if #(.ERR_W(4)) if2 ();

  gate_sweep_checker #(.NUM_PASSES(1), .SETTLE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  gate_sweep_checker #(.NUM_PASSES(2), .SETTLE_CYCLES(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  // Gate block under test, with a selectable planted fault
  function automatic logic [6:0] gate_fn(input logic a, input logic b, input int f);
    logic [6:0] g;
    g[0] = a & b;
    g[1] = a | b;
    g[2] = ~a;
    g[3] = ~(a & b);
    g[4] = ~(a | b);
    g[5] = a ^ b;
    g[6] = ~(a ^ b);
    case (f)
      1: g[5] = ~g[5];   // XOR inverted
      2: g[1] = 1'b0;    // OR stuck-at-0
      3: g[3] = 1'b1;    // NAND stuck-at-1
      4: g[0] = 1'b0;    // AND stuck-at-0
      5: g[2] = ~g[2];   // NOT inverted
      6: g[6] = 1'b1;    // XNOR stuck-at-1
      default: ;
    endcase
    return g;
  endfunction

  assign if1.start    = start1;
  assign if2.start    = start2;
  assign if1.gate_out = gate_fn(if1.a, if1.b, fault1);
  assign if2.gate_out = gate_fn(if2.a, if2.b, fault2);

  logic       m_done, m_busy, m_pass, m_ffv;
  logic [3:0] m_err;
  logic [6:0] m_mask, m_ffobs;
  logic [1:0] m_ffvec;

  assign m_done  = (dsel == 1) ? if2.done : if1.done;
  assign m_busy  = (dsel == 1) ? if2.busy : if1.busy;
  assign m_pass  = (dsel == 1) ? if2.pass : if1.pass;
  assign m_ffv   = (dsel == 1) ? if2.first_fail_valid : if1.first_fail_valid;
  assign m_err   = (dsel == 1) ? if2.err_count : {1'b0, if1.err_count};
  assign m_mask  = (dsel == 1) ? if2.fail_mask : if1.fail_mask;
  assign m_ffobs = (dsel == 1) ? if2.first_fail_obs : if1.first_fail_obs;
  assign m_ffvec = (dsel == 1) ? if2.first_fail_vec : if1.first_fail_vec;

  typedef struct {
    int         sel;
    int         fault;
    int         lat;
    logic       pass;
    int         err;
    logic [6:0] mask;
    logic       ffv;
    logic [1:0] ffvec;
    logic [6:0] ffobs;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    dsel = v.sel;
    if (v.sel == 1) fault2 = v.fault; else fault1 = v.fault;
    @(negedge clk);
    if (v.sel == 1) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    chk($sformatf("v%0d_busy_on", idx), m_busy, 1);
    n = 1;
    while (!m_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d_done_cycle", idx), n, v.lat);
    chk($sformatf("v%0d_busy_in_done", idx), m_busy, 0);
    chk($sformatf("v%0d_pass", idx), m_pass, v.pass);
    chk($sformatf("v%0d_err_count", idx), m_err, v.err);
    chk($sformatf("v%0d_fail_mask", idx), m_mask, v.mask);
`ifdef GATE_CHK_FIRST_FAIL_EN
    chk($sformatf("v%0d_ff_valid", idx), m_ffv, v.ffv);
    chk($sformatf("v%0d_ff_vec", idx), m_ffvec, v.ffvec);
    chk($sformatf("v%0d_ff_obs", idx), m_ffobs, v.ffobs);
`else
    chk($sformatf("v%0d_ff_valid_tied", idx), m_ffv, 0);
    chk($sformatf("v%0d_ff_obs_tied", idx), m_ffobs, 0);
`endif
    @(posedge clk); #1;
    chk($sformatf("v%0d_done_pulse", idx), m_done, 0);
    chk($sformatf("v%0d_idle_after", idx), m_busy, 0);
  endtask

  initial begin
    int n;
    int done_seen;

    //            sel flt lat pass err mask        ffv vec    obs
    tbl[0] = '{0, 0,  9, 1'b1, 0, 7'b0000000, 1'b0, 2'b00, 7'b0000000};
    tbl[1] = '{0, 1,  9, 1'b0, 4, 7'b0100000, 1'b1, 2'b00, 7'b1111100};
    tbl[2] = '{0, 2,  9, 1'b0, 3, 7'b0000010, 1'b1, 2'b01, 7'b0101100};
    tbl[3] = '{0, 3,  9, 1'b0, 1, 7'b0001000, 1'b1, 2'b11, 7'b1001011};
    tbl[4] = '{0, 4,  9, 1'b0, 1, 7'b0000001, 1'b1, 2'b11, 7'b1000010};
    tbl[5] = '{0, 5,  9, 1'b0, 4, 7'b0000100, 1'b1, 2'b00, 7'b1011000};
    tbl[6] = '{0, 6,  9, 1'b0, 2, 7'b1000000, 1'b1, 2'b01, 7'b1101110};
    tbl[7] = '{1, 0, 33, 1'b1, 0, 7'b0000000, 1'b0, 2'b00, 7'b0000000};
    tbl[8] = '{1, 3, 33, 1'b0, 2, 7'b0001000, 1'b1, 2'b11, 7'b1001011};
    tbl[9] = '{1, 1, 33, 1'b0, 8, 7'b0100000, 1'b1, 2'b00, 7'b1111100};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", if1.a, 0);
    chk("rst_b", if1.b, 0);
    chk("rst_busy", if1.busy, 0);
    chk("rst_done", if1.done, 0);
    chk("rst_pass", if1.pass, 0);
    chk("rst_err", if1.err_count, 0);
    chk("rst_mask", if1.fail_mask, 0);
    chk("rst_ffv", if1.first_fail_valid, 0);
    chk("rst_ffobs", if1.first_fail_obs, 0);
    chk("rst_busy2", if2.busy, 0);
    rst = 1'b0;

    // Table runs, back to back (each start lands in the cycle after DONE)
    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Reset mid-run: XOR fault so err_count is already nonzero at k+4
    dsel   = 0;
    fault1 = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("midrst_busy_k4", if1.busy, 1);
    chk("midrst_err_k4", if1.err_count, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", if1.busy, 0);
    chk("midrst_done", if1.done, 0);
    chk("midrst_err", if1.err_count, 0);
    chk("midrst_mask", if1.fail_mask, 0);
    chk("midrst_pass", if1.pass, 0);
    chk("midrst_a", if1.a, 0);
    chk("midrst_b", if1.b, 0);
    chk("midrst_ffv", if1.first_fail_valid, 0);
    done_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (if1.done) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);

    // start pulsed while busy and in DONE is ignored
    fault1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 1;
    while (!if1.done && n < 200) begin
      start1 = (n == 3 || n == 8) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("ign_done_cycle", n, 9);
    chk("ign_pass", if1.pass, 1);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("ign_start_in_done", if1.busy, 0);

    // rst and start together: reset wins
    start1 = 1'b1;
    rst    = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    rst    = 1'b0;
    chk("rst_start_busy", if1.busy, 0);
    @(posedge clk); #1;
    chk("rst_start_stays_idle", if1.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential self-check stage wrapped around the seven-output basic-gate block. It drives the gate's `a`/`b` inputs through all four input combinations, one or more times. It consumes the seven gate outputs one settle interval after each vector, compares them with a golden truth table, and reports a per-run verdict, a mismatch count and a sticky per-gate failure mask. It serves as the on-chip BIST and bring-up monitor for the gate block.

## Interface
Parameters:
- `NUM_PASSES`, default 1: full 4-vector sweeps per run. Must be ≥1.
- `SETTLE_CYCLES`, default 1: cycles between applying a vector and sampling the outputs. Must be ≥1; 0 is illegal.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `a`, `b` out 1 each: drive the gate block inputs.
- `gate_out` in 7: observed outputs `{xnor,xor,nor,nand,not,or,and}`. Bit 0 is AND, bit 6 is XNOR.
- `busy` out 1: high in DRIVE and CHECK.
- `done` out 1: one-cycle pulse in DONE.
- `pass` out 1: run verdict, held until the next accepted `start`.
- `err_count` out `$clog2(4*NUM_PASSES+1)`: number of mismatching vectors.
- `fail_mask` out 7: sticky OR of per-gate mismatches.
- `first_fail_valid` out 1, `first_fail_vec` out 2 (`{a,b}`), `first_fail_obs` out 7: first-failure capture (see Configuration).

## Operation
- **FSM states:** IDLE, DRIVE, CHECK, DONE.
- **IDLE → DRIVE** when `start`=1. On this transition:
  - clear `err_count`, `fail_mask`, `pass` and the first-fail registers;
  - set the vector to 00 and the pass counter to 0.
- **DRIVE:**
  - `{a,b}` holds the current vector.
  - The settle counter counts `SETTLE_CYCLES` cycles, then the FSM moves to CHECK.
- **CHECK:** compare `gate_out` with the expected value of the current vector.
  - Any bit mismatch increments `err_count` by 1, once per vector regardless of how many gates fail.
  - Mismatching bits are ORed into `fail_mask`.
  - Next transition:
    - vector < 11: advance to the next vector and return to DRIVE;
    - vector = 11 and more passes remain: set vector to 00, increment the pass counter, return to DRIVE;
    - otherwise: go to DONE.
- **DONE:** `done`=1 and `pass` is registered as (`err_count`==0 including the final vector). Next state is IDLE.
- **Vector order:** 00, 01, 10, 11, with `a` as the MSB.
- **Expected values:** AND=a&b, OR=a|b, NOT=~a, NAND=~(a&b), NOR=~(a|b), XOR=a^b, XNOR=~(a^b).
- **Boundary conditions:**
  - `start` while busy or in DONE is ignored.
  - `rst` and `start` in the same cycle: `rst` wins.
  - `rst` mid-run returns the FSM to IDLE and clears everything; no `done` is produced.
  - `err_count` cannot overflow given its width; it saturates defensively.

## Timing
- **Reset values:** `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0, all first-fail outputs 0, state IDLE.
- **Run timing:** with `start` seen at edge k:
  - `busy`=1 from cycle k+1;
  - `done` pulses in cycle k+1+4·NUM_PASSES·(SETTLE_CYCLES+1), and `busy` is 0 in that cycle.
- **Per vector:** SETTLE_CYCLES cycles in DRIVE plus 1 cycle in CHECK.
- **Output stability:** `a`/`b` change only on DRIVE entry, so `gate_out` is sampled at least SETTLE_CYCLES cycles after its inputs change.
- **Back-to-back runs:** the earliest next `start` is accepted in the cycle after DONE.

## Configuration
- **`GATE_CHK_FIRST_FAIL_EN` defined:**
  - On the first mismatching CHECK of a run, latch `first_fail_vec` and `first_fail_obs` (the raw `gate_out`) and set `first_fail_valid`.
  - These hold until the next accepted `start` or `rst`.
- **Macro undefined:** the ports remain present, tied to 0, with no capture registers.

## Structure
- **Package `gate_chk_pkg`:**
  - FSM state enum;
  - gate bit-index constants (`IDX_AND`=0 … `IDX_XNOR`=6);
  - `NUM_VEC`=4;
  - function `gate_expect(a,b)` returning 7 bits.
- **Sub-module `gate_expect_model`:** combinational golden model wrapping the package function. It is instantiated once and is reusable by the bench.

## Test plan
- **Golden gate, defaults:** `start` at edge k → `done` in cycle k+9, `pass`=1, `err_count`=0, `fail_mask`=0.
- **XOR output inverted:** all 4 vectors fail → `err_count`=4, `fail_mask`=7'b0100000, `pass`=0.
- **OR stuck-at-0:** vectors 01, 10, 11 fail → `err_count`=3, `fail_mask`=7'b0000010.
- **NUM_PASSES=2, SETTLE_CYCLES=3, NAND stuck-at-1:** 11 fails in each pass → `err_count`=2, `fail_mask`=7'b0001000, `done` at k+33.
- **Reset and ignored start:**
  - `rst` at cycle k+4 → IDLE next cycle with all outputs at reset values, no `done`;
  - `start` pulsed while `busy` → run length unchanged.
- **With `GATE_CHK_FIRST_FAIL_EN`, AND stuck-at-0:** `first_fail_valid`=1, `first_fail_vec`=2'b11, `first_fail_obs`=7'b1000010.
